// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and its monitor:
// phase codes, lamp patterns, monitor FSM states and decode helpers.
package traffic_pkg;

    localparam logic [1:0] PH_RED  = 2'd0;
    localparam logic [1:0] PH_YEL  = 2'd1;
    localparam logic [1:0] PH_GRN  = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    localparam logic [2:0] LED_OFF = 3'b000;
    localparam logic [2:0] LED_RED = 3'b100;
    localparam logic [2:0] LED_YEL = 3'b010;
    localparam logic [2:0] LED_GRN = 3'b001;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_e;

    // Dark and multi-lamp patterns both decode to PH_NONE; callers that
    // need to tell them apart compare against LED_OFF.
    function automatic logic [1:0] decode_led(input logic [2:0] pat);
        case (pat)
            LED_RED: return PH_RED;
            LED_YEL: return PH_YEL;
            LED_GRN: return PH_GRN;
            default: return PH_NONE;
        endcase
    endfunction

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        case (ph)
            PH_RED:  return PH_YEL;
            PH_YEL:  return PH_GRN;
            PH_GRN:  return PH_RED;
            default: return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Divides the system clock down to a one-cycle pulse every CLK_HZ cycles.
// A restart re-aligns the count so the next pulse lands CLK_HZ cycles later.
module sec_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A restart swallows a coinciding wrap so a new phase never starts with a stray tick.
    assign o_tick = (r_cnt == CNT_MAX) && !i_restart;

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches the controller's lamp bus, decodes the phase, drives a seconds
// countdown and raises sticky sequence/timing error flags.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int RED_S  = 6,
    parameter int YEL_S  = 2,
    parameter int GRN_S  = 6,
    parameter int TOL_S  = 1
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic [2:0] led,
    input  logic       clr_err,
    output logic [1:0] phase,
    output logic [3:0] sec_left,
    output logic       locked,
    output logic       err_seq,
    output logic       err_time,
    output logic [7:0] cycles,
    output mon_state_e dbg_state
);

    function automatic int exp_of(input logic [1:0] ph);
        case (ph)
            PH_RED:  return RED_S;
            PH_YEL:  return YEL_S;
            PH_GRN:  return GRN_S;
            default: return 0;
        endcase
    endfunction

    logic [2:0] r_sync1, r_sync2, r_prev;
    logic [1:0] r_phase;
    logic [3:0] r_secs, r_sec_left;
    logic       r_locked, r_err_seq, r_err_time, r_dirty;
    logic [7:0] r_cycles;
    mon_state_e r_state;

    logic [1:0] w_dec;
    logic       w_illegal, w_chg, w_tick, w_time_bad, w_overrun;
    int         w_exp_end, w_exp_new;
    logic [3:0] w_secs_n, w_sec_left_n;
    logic       w_locked_n, w_err_seq_n, w_err_time_n, w_dirty_n;
    logic [7:0] w_cycles_n;
    mon_state_e w_state_n;

    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .i_clk    (clk_50m),
        .i_rst    (rst),
        .i_restart(w_chg),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_dec      = decode_led(r_sync2);
        w_illegal  = (w_dec == PH_NONE) && (r_sync2 != LED_OFF);
        w_chg      = (r_sync2 != r_prev);
        w_exp_end  = exp_of(r_phase);
        w_time_bad = (int'(r_secs) < w_exp_end - TOL_S) || (int'(r_secs) > w_exp_end + TOL_S);
        w_overrun  = w_tick && (int'(r_secs) == w_exp_end + TOL_S);
    end

    always_comb begin
        w_state_n    = r_state;
        w_secs_n     = r_secs;
        w_locked_n   = r_locked;
        w_err_seq_n  = r_err_seq;
        w_err_time_n = r_err_time;
        w_dirty_n    = r_dirty;
        w_cycles_n   = r_cycles;
        w_sec_left_n = 4'd0;
        w_exp_new    = exp_of(w_dec);

        if (w_chg) begin
            w_secs_n = 4'd0;
        end else if (w_tick && (r_secs != 4'd15)) begin
            w_secs_n = r_secs + 4'd1;
        end

        case (r_state)
            ST_INIT: begin
                if (w_illegal) begin
                    w_err_seq_n = 1'b1;
                    w_state_n   = ST_FAULT;
                end else if (w_dec == PH_RED) begin
                    w_secs_n  = 4'd0;
                    w_dirty_n = 1'b0;
                    w_state_n = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (w_chg) begin
                    if (w_time_bad) begin
                        w_err_time_n = 1'b1;
                        w_dirty_n    = 1'b1;
                    end
                    if (w_dec != next_phase(r_phase)) begin
                        w_err_seq_n = 1'b1;
                        w_locked_n  = 1'b0;
                        w_state_n   = ST_FAULT;
                    end else if (w_dec == PH_RED) begin
                        if (!(r_dirty || w_time_bad)) begin
                            w_cycles_n = r_cycles + 8'd1;
                            w_locked_n = 1'b1;
                        end
                        w_dirty_n = 1'b0;
                    end
                end else if (w_overrun) begin
                    w_err_time_n = 1'b1;
                    w_dirty_n    = 1'b1;
                end
            end
            default: begin
                w_locked_n = 1'b0;
            end
        endcase

        // Clearing beats any flag-setting event in the same cycle.
        if (clr_err) begin
            w_err_seq_n  = 1'b0;
            w_err_time_n = 1'b0;
            w_locked_n   = 1'b0;
            w_dirty_n    = 1'b0;
            w_cycles_n   = r_cycles;
            w_state_n    = ST_INIT;
        end

        if ((w_state_n == ST_TRACK) && (w_dec != PH_NONE) && (int'(w_secs_n) < w_exp_new)) begin
            w_sec_left_n = 4'(w_exp_new - int'(w_secs_n));
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_sync1    <= LED_OFF;
            r_sync2    <= LED_OFF;
            r_prev     <= LED_OFF;
            r_phase    <= PH_NONE;
            r_secs     <= 4'd0;
            r_sec_left <= 4'd0;
            r_locked   <= 1'b0;
            r_err_seq  <= 1'b0;
            r_err_time <= 1'b0;
            r_dirty    <= 1'b0;
            r_cycles   <= 8'd0;
            r_state    <= ST_INIT;
        end else begin
            r_sync1    <= led;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_phase    <= w_dec;
            r_secs     <= w_secs_n;
            r_sec_left <= w_sec_left_n;
            r_locked   <= w_locked_n;
            r_err_seq  <= w_err_seq_n;
            r_err_time <= w_err_time_n;
            r_dirty    <= w_dirty_n;
            r_cycles   <= w_cycles_n;
            r_state    <= w_state_n;
        end
    end

    assign phase     = r_phase;
    assign sec_left  = r_sec_left;
    assign locked    = r_locked;
    assign err_seq   = r_err_seq;
    assign err_time  = r_err_time;
    assign cycles    = r_cycles;
    assign dbg_state = r_state;

endmodule
